// File: rtl/param_reg_file_if.sv
// Bus bundle for param_reg_file: load/function controls in, two read ports and wrap flags out.
interface param_reg_file_if #(
    parameter int WIDTH    = 8,
    parameter int NUM_REGS = 8,
    parameter int SELW     = 3
);
    logic [WIDTH-1:0]    I;
    logic [1:0]          FunSel;
    logic [NUM_REGS-1:0] RSel;
    logic [SELW-1:0]     O1Sel;
    logic [SELW-1:0]     O2Sel;
    logic [WIDTH-1:0]    O1;
    logic [WIDTH-1:0]    O2;
    logic [NUM_REGS-1:0] WrapFlag;
    logic                AnyWrap;

    modport master (
        output I, FunSel, RSel, O1Sel, O2Sel,
        input  O1, O2, WrapFlag, AnyWrap
    );

    modport slave (
        input  I, FunSel, RSel, O1Sel, O2Sel,
        output O1, O2, WrapFlag, AnyWrap
    );
endinterface

// File: rtl/param_reg_file.sv
// Parametrised register file: mask-selected clear/load/dec/inc, two registered read ports,
// optional saturation and write-through bypass, sticky per-register wrap flags.
module param_reg_file #(
    parameter int              WIDTH     = 8,
    parameter int              NUM_REGS  = 8,
    parameter int              SELW      = 3,
    parameter int              SAT       = 0,
    parameter int              BYPASS    = 0,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input logic              clk,
    input logic              rst_n,
    param_reg_file_if.slave  bus
);

    localparam logic [WIDTH-1:0] ALL_ONES = '1;
    localparam logic [WIDTH-1:0] ZERO     = '0;
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
    // Value produced when a dec underflows or an inc overflows.
    localparam logic [WIDTH-1:0] DEC_EDGE = (SAT != 0) ? ZERO : ALL_ONES;
    localparam logic [WIDTH-1:0] INC_EDGE = (SAT != 0) ? ALL_ONES : ZERO;

    logic [WIDTH-1:0]    regs_q [NUM_REGS];
    logic [WIDTH-1:0]    regs_d [NUM_REGS];
    logic [NUM_REGS-1:0] wrap_q;
    logic [NUM_REGS-1:0] wrap_d;
    logic [WIDTH-1:0]    o1_q;
    logic [WIDTH-1:0]    o1_d;
    logic [WIDTH-1:0]    o2_q;
    logic [WIDTH-1:0]    o2_d;
    logic                any_q;

    always_comb begin
        for (int k = 0; k < NUM_REGS; k++) begin
            regs_d[k] = regs_q[k];
            wrap_d[k] = wrap_q[k];
            if (bus.RSel[k]) begin
                case (bus.FunSel)
                    2'b00: begin
                        regs_d[k] = ZERO;
                        wrap_d[k] = 1'b0;
                    end
                    2'b01: begin
                        regs_d[k] = bus.I;
                        wrap_d[k] = 1'b0;
                    end
                    2'b10: begin
                        if (regs_q[k] == ZERO) begin
                            regs_d[k] = DEC_EDGE;
                            wrap_d[k] = 1'b1;
                        end else begin
                            regs_d[k] = regs_q[k] - ONE;
                        end
                    end
                    default: begin
                        if (regs_q[k] == ALL_ONES) begin
                            regs_d[k] = INC_EDGE;
                            wrap_d[k] = 1'b1;
                        end else begin
                            regs_d[k] = regs_q[k] + ONE;
                        end
                    end
                endcase
            end
        end
    end

    // Out-of-range selects match no register and leave the port at zero.
    always_comb begin
        o1_d = ZERO;
        o2_d = ZERO;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (bus.O1Sel == SELW'(k)) begin
                o1_d = (BYPASS != 0) ? regs_d[k] : regs_q[k];
            end
            if (bus.O2Sel == SELW'(k)) begin
                o2_d = (BYPASS != 0) ? regs_d[k] : regs_q[k];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                regs_q[k] <= RESET_VAL;
            end
            wrap_q <= '0;
            o1_q   <= ZERO;
            o2_q   <= ZERO;
            any_q  <= 1'b0;
        end else begin
            for (int k = 0; k < NUM_REGS; k++) begin
                regs_q[k] <= regs_d[k];
            end
            wrap_q <= wrap_d;
            o1_q   <= o1_d;
            o2_q   <= o2_d;
            any_q  <= |wrap_d;
        end
    end

    assign bus.O1       = o1_q;
    assign bus.O2       = o2_q;
    assign bus.WrapFlag = wrap_q;
    assign bus.AnyWrap  = any_q;

endmodule

// File: tb/tb_param_reg_file.sv
// Random + directed bench for param_reg_file: two instances (wrap/no-bypass, saturate/bypass)
// compared against an integer reference model.
module tb_param_reg_file;

    localparam int MAXV = 255;
    localparam int NA   = 8;
    localparam int NB   = 6;
    localparam int RVB  = 8'h3C;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] i_v;
    logic [1:0] fs_v;
    logic [7:0] rsel_v;
    logic [2:0] o1s;
    logic [2:0] o2s;

    always #5 clk = ~clk;

    param_reg_file_if #(.WIDTH(8), .NUM_REGS(NA), .SELW(3)) bus_a ();
    param_reg_file_if #(.WIDTH(8), .NUM_REGS(NB), .SELW(3)) bus_b ();

    assign bus_a.I      = i_v;
    assign bus_a.FunSel = fs_v;
    assign bus_a.RSel   = rsel_v;
    assign bus_a.O1Sel  = o1s;
    assign bus_a.O2Sel  = o2s;
    assign bus_b.I      = i_v;
    assign bus_b.FunSel = fs_v;
    assign bus_b.RSel   = rsel_v[NB-1:0];
    assign bus_b.O1Sel  = o1s;
    assign bus_b.O2Sel  = o2s;

    param_reg_file #(.WIDTH(8), .NUM_REGS(NA), .SELW(3), .SAT(0), .BYPASS(0),
                     .RESET_VAL(8'h00)) u_dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a)
    );

    param_reg_file #(.WIDTH(8), .NUM_REGS(NB), .SELW(3), .SAT(1), .BYPASS(1),
                     .RESET_VAL(8'h3C)) u_dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b)
    );

    int ma [NA];
    bit fa [NA];
    int mb [NB];
    bit fb [NB];
    int exp_a1, exp_a2, exp_b1, exp_b2;
    int errs   = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int nxt(input int v, input logic [1:0] fs, input int iv,
                               input bit sat, output bit wrap);
        int r;
        wrap = 1'b0;
        case (fs)
            2'd0: r = 0;
            2'd1: r = iv;
            2'd2: begin
                if (v == 0) begin
                    wrap = 1'b1;
                    r = sat ? 0 : MAXV;
                end else r = v - 1;
            end
            default: begin
                if (v == MAXV) begin
                    wrap = 1'b1;
                    r = sat ? MAXV : 0;
                end else r = v + 1;
            end
        endcase
        return r;
    endfunction

    function automatic bit nflag(input bit old, input logic [1:0] fs, input bit wrap);
        if (fs <= 2'd1) return 1'b0;
        return wrap ? 1'b1 : old;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NA; k++) begin ma[k] = 0;   fa[k] = 1'b0; end
        for (int k = 0; k < NB; k++) begin mb[k] = RVB; fb[k] = 1'b0; end
    endtask

    task automatic check_outputs(input string pfx);
        logic [7:0] ewa;
        logic [5:0] ewb;
        for (int k = 0; k < NA; k++) ewa[k] = fa[k];
        for (int k = 0; k < NB; k++) ewb[k] = fb[k];
        chk({pfx, " A.O1"},   32'(bus_a.O1),       32'(exp_a1));
        chk({pfx, " A.O2"},   32'(bus_a.O2),       32'(exp_a2));
        chk({pfx, " A.wrap"}, 32'(bus_a.WrapFlag), 32'(ewa));
        chk({pfx, " A.any"},  32'(bus_a.AnyWrap),  32'(|ewa));
        chk({pfx, " B.O1"},   32'(bus_b.O1),       32'(exp_b1));
        chk({pfx, " B.O2"},   32'(bus_b.O2),       32'(exp_b2));
        chk({pfx, " B.wrap"}, 32'(bus_b.WrapFlag), 32'(ewb));
        chk({pfx, " B.any"},  32'(bus_b.AnyWrap),  32'(|ewb));
    endtask

    // One clock edge: advance the model with the applied inputs, then check after the edge.
    task automatic cycle(input string pfx);
        int na [NA];
        int nb [NB];
        bit w;
        @(posedge clk);
        for (int k = 0; k < NA; k++) begin
            na[k] = ma[k];
            if (rsel_v[k]) begin
                na[k] = nxt(ma[k], fs_v, int'(i_v), 1'b0, w);
                fa[k] = nflag(fa[k], fs_v, w);
            end
        end
        exp_a1 = (int'(o1s) < NA) ? ma[o1s] : 0;
        exp_a2 = (int'(o2s) < NA) ? ma[o2s] : 0;
        ma = na;
        for (int k = 0; k < NB; k++) begin
            nb[k] = mb[k];
            if (rsel_v[k]) begin
                nb[k] = nxt(mb[k], fs_v, int'(i_v), 1'b1, w);
                fb[k] = nflag(fb[k], fs_v, w);
            end
        end
        mb = nb;
        exp_b1 = 0;
        exp_b2 = 0;
        for (int k = 0; k < NB; k++) begin
            if (int'(o1s) == k) exp_b1 = mb[k];
            if (int'(o2s) == k) exp_b2 = mb[k];
        end
        #1;
        check_outputs(pfx);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        exp_a1 = 0; exp_a2 = 0; exp_b1 = 0; exp_b2 = 0;
        check_outputs("async_rst");
        @(negedge clk);
        @(negedge clk);
        check_outputs("rst_held");
        rst_n = 1'b1;
    endtask

    initial begin
        i_v = 8'h00; fs_v = 2'b00; rsel_v = 8'h00; o1s = 3'd0; o2s = 3'd0;
        model_reset();
        exp_a1 = 0; exp_a2 = 0; exp_b1 = 0; exp_b2 = 0;
        @(negedge clk);
        check_outputs("por");
        @(negedge clk);
        rst_n = 1'b1;

        o1s = 3'd3; o2s = 3'd3;
        cycle("post_rst");
        chk("post_rst B.O1 resetval", 32'(bus_b.O1), 32'h3C);

        fs_v = 2'b01; i_v = 8'h5A; rsel_v = 8'h85; o1s = 3'd2; o2s = 3'd7;
        cycle("mload");
        chk("mload B.O1 same edge", 32'(bus_b.O1), 32'h5A);
        chk("mload A.O1 pre edge",  32'(bus_a.O1), 32'h00);
        rsel_v = 8'h00;
        cycle("mload2");
        chk("mload A.O1 next edge", 32'(bus_a.O1), 32'h5A);

        fs_v = 2'b01; i_v = 8'hFF; rsel_v = 8'h02; o1s = 3'd1; o2s = 3'd0;
        cycle("wrap_ld");
        fs_v = 2'b11;
        cycle("wrap_inc1");
        chk("wrap A.any after wrap", 32'(bus_a.AnyWrap), 32'h1);
        cycle("wrap_inc2");
        chk("wrap A.flag sticky", 32'(bus_a.WrapFlag[1]), 32'h1);
        fs_v = 2'b01; i_v = 8'h10;
        cycle("wrap_clr");
        chk("wrap A.flag cleared", 32'(bus_a.WrapFlag[1]), 32'h0);

        fs_v = 2'b00; rsel_v = 8'h10; o1s = 3'd4;
        cycle("sat_clr");
        fs_v = 2'b10;
        repeat (3) cycle("sat_dec");
        chk("sat B.O1 floor", 32'(bus_b.O1), 32'h00);
        chk("sat B.flag floor", 32'(bus_b.WrapFlag[4]), 32'h1);
        fs_v = 2'b01; i_v = 8'hFE;
        cycle("sat_ld");
        fs_v = 2'b11;
        cycle("sat_inc1");
        chk("sat B.flag first inc", 32'(bus_b.WrapFlag[4]), 32'h0);
        cycle("sat_inc2");
        chk("sat B.O1 ceil", 32'(bus_b.O1), 32'hFF);
        chk("sat B.flag ceil", 32'(bus_b.WrapFlag[4]), 32'h1);

        rsel_v = 8'h00; o1s = 3'd5; o2s = 3'd5;
        cycle("dual");
        o2s = 3'd7;
        cycle("oor");
        chk("oor B.O2 zero", 32'(bus_b.O2), 32'h0);

        repeat (6) begin
            fs_v = 2'b11; rsel_v = 8'($urandom);
            o1s = 3'($urandom); o2s = 3'($urandom);
            cycle("mix_inc");
        end
        fs_v = 2'b00; rsel_v = 8'hFF;
        cycle("clr_all");
        rsel_v = 8'h00;
        cycle("clr_after");
        chk("clr A.any", 32'(bus_a.AnyWrap), 32'h0);
        chk("clr B.any", 32'(bus_b.AnyWrap), 32'h0);

        fs_v = 2'b11; rsel_v = 8'hFF;
        cycle("pre_rst");
        do_reset();
        rsel_v = 8'h00; o1s = 3'd3; o2s = 3'd3;
        cycle("rst2");
        chk("rst2 B.O1 resetval", 32'(bus_b.O1), 32'h3C);

        for (int n = 0; n < 600; n++) begin
            int r;
            r = $urandom_range(0, 9);
            fs_v = (r == 0) ? 2'b00 : (r <= 2) ? 2'b01 : (r <= 5) ? 2'b10 : 2'b11;
            case ($urandom_range(0, 4))
                0: i_v = 8'h00;
                1: i_v = 8'h01;
                2: i_v = 8'hFE;
                3: i_v = 8'hFF;
                default: i_v = 8'($urandom);
            endcase
            rsel_v = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            o1s = 3'($urandom);
            o2s = ($urandom_range(0, 3) == 0) ? o1s : 3'($urandom);
            cycle("rand");
            if ((n % 200) == 199) do_reset();
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
